uart_tx_ser: RTL and testbench

- UART transmit serializer for the TX path of the UART_APB block.
- Pops bytes from the upstream TX buffer over a valid/ready handshake.
- Shifts each byte out on the serial line: start bit, LSB-first data, optional parity, stop bit(s).
- Baud timing comes from an internal clocks-per-bit counter, so the block needs no external tick.

---
 rtl/uart_tx_ser.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_ser.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ser.sv
// uart_tx_ser: UART transmit serializer for the UART_APB TX path.
//
// Accepts a byte from the upstream TX buffer over a valid/ready handshake.
// It then shifts out a start bit, the data bits LSB-first, an optional even
// parity bit and STOP_BITS stop bits. Each serial bit lasts CLK_DIV clk cycles,
// and that timing comes from an internal baud counter.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// after the data bits. When it is undefined there is no PARITY state and no
// parity register.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   data_i    in   byte to transmit, sampled on handshake
//   valid_in  in   upstream has a byte
//   ready_in  out  serializer can accept a byte (IDLE and not in reset)
//   tx_o      out  registered serial line, idles high
//   busy_o    out  a frame is in progress
module uart_tx_ser #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_in,
  output logic                  ready_in,
  output logic                  tx_o,
  output logic                  busy_o
);

  localparam int unsigned BaudW = $clog2(CLK_DIV);
  localparam int unsigned BitW  = $clog2(DATA_WIDTH) + 1;

  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLK_DIV - 1);
  localparam logic [BaudW-1:0] BaudOne  = BaudW'(1);
  localparam logic [BitW-1:0]  DataLast = BitW'(DATA_WIDTH - 1);
  localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);
  localparam logic [BitW-1:0]  BitOne   = BitW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e                  state_q;
  logic                    tx_q;
  logic [BaudW-1:0]        baud_q;
  logic [BitW-1:0]         bit_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [DATA_WIDTH-1:0]   shift_nxt;
  logic                    baud_wrap;
`ifdef UART_TX_PARITY_EN
  logic                    par_q;
`endif

  assign shift_nxt = {1'b0, shift_q[DATA_WIDTH-1:1]};
  assign baud_wrap = (baud_q == BaudLast);

  assign ready_in = (state_q == StIdle) & ~rst;
  assign busy_o   = (state_q != StIdle);
  assign tx_o     = tx_q;

  // tx_q is loaded together with each state change so that the line level
  // always matches the state that is being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tx_q    <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (valid_in) begin
            state_q <= StStart;
            tx_q    <= 1'b0;
            shift_q <= data_i;
            baud_q  <= '0;
            bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^data_i;
`endif
          end
        end

        StStart: begin
          if (baud_wrap) begin
            baud_q  <= '0;
            state_q <= StData;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + BaudOne;
          end
        end

        StData: begin
          if (baud_wrap) begin
            baud_q  <= '0;
            shift_q <= shift_nxt;
            if (bit_q == DataLast) begin
              bit_q <= '0;
`ifdef UART_TX_PARITY_EN
              state_q <= StParity;
              tx_q    <= par_q;
`else
              state_q <= StStop;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q <= bit_q + BitOne;
              tx_q  <= shift_nxt[0];
            end
          end else begin
            baud_q <= baud_q + BaudOne;
          end
        end

`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (baud_wrap) begin
            baud_q  <= '0;
            state_q <= StStop;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q + BaudOne;
          end
        end
`endif

        StStop: begin
          // bit_q counts stop-bit periods when STOP_BITS is 2.
          if (baud_wrap) begin
            baud_q <= '0;
            if (bit_q == StopLast) begin
              bit_q   <= '0;
              state_q <= StIdle;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + BitOne;
            end
          end else begin
            baud_q <= baud_q + BaudOne;
          end
        end

        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ser.sv
// Bench for uart_tx_ser with CLK_DIV=4. A frame-level model predicts tx_o,
// busy_o and ready_in on every cycle. Directed literal checks pin the
// expected waveforms independently of that model.
module tb_uart_tx_ser;

  localparam int unsigned DW = 8;
  localparam int unsigned CD = 4;
  localparam int unsigned SB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif
  localparam int FRAME = (1 + DW + PB + SB) * CD;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic       ready_in;
  logic       tx_o;
  logic       busy_o;
  logic [7:0] data_i;

  int vectors = 0;
  int errs    = 0;
  int rel     = 0;

  // Model: pos is the cycle index inside the current frame, -1 when idle.
  int   pos   = -1;
  bit   armed = 1'b0;
  logic fbits [0:15];

  initial forever #5 clk = ~clk;

  uart_tx_ser #(
    .DATA_WIDTH(DW),
    .CLK_DIV   (CD),
    .STOP_BITS (SB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_in(valid_in),
    .ready_in(ready_in),
    .tx_o    (tx_o),
    .busy_o  (busy_o)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each edge from the sampled inputs, then compare just after.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        pos   = -1;
        armed = 1'b1;
      end else if (pos < 0) begin
        if (valid_in) begin
          fbits[0] = 1'b0;
          for (int i = 0; i < DW; i++) fbits[1+i] = data_i[i];
          if (PB != 0) fbits[1+DW] = ^data_i;
          for (int s = 0; s < SB; s++) fbits[1+DW+PB+s] = 1'b1;
          pos = 0;
        end
      end else begin
        pos++;
        if (pos == FRAME) pos = -1;
      end
      #1;
      if (armed) begin
        chk("model_tx", tx_o, (pos < 0) ? 1'b1 : fbits[pos/CD]);
        chk("model_busy", busy_o, pos >= 0);
        chk("model_ready", ready_in, (pos < 0) && !rst);
      end
    end
  end

  task automatic at(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic goto(input int target);
    at(target - rel);
    rel = target;
  endtask

  // Handshake from idle; returns in cycle T+1 with valid_in dropped.
  task automatic launch(input logic [7:0] d);
    at(1);
    valid_in = 1'b1;
    data_i   = d;
    @(posedge clk);
    at(1);
    valid_in = 1'b0;
    rel      = 1;
  endtask

  logic exp_a5 [0:10];

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    data_i   = 8'h00;

    // Reset held for 3 cycles.
    for (int k = 0; k < 3; k++) begin
      at(1);
      chk("rst_tx", tx_o, 1'b1);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_ready", ready_in, 1'b0);
    end
    rst = 1'b0;
    #1;
    chk("rel_ready", ready_in, 1'b1);
    chk("rel_tx", tx_o, 1'b1);

    // Single frame 8'hA5.
    exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
`ifdef UART_TX_PARITY_EN
               1'b0, 1'b1};
`else
               1'b1, 1'b1};
`endif
    launch(8'hA5);
    data_i = 8'h00;
    chk("a5_fall", tx_o, 1'b0);
    for (int b = 0; b < 10 + PB; b++) begin
      goto(2 + 4 * b);
      chk("a5_bit", tx_o, exp_a5[b]);
    end
    goto(FRAME);
    chk("a5_busy_end", busy_o, 1'b1);
    chk("a5_ready_lo", ready_in, 1'b0);
    goto(FRAME + 1);
    chk("a5_ready_hi", ready_in, 1'b1);
    chk("a5_idle_busy", busy_o, 1'b0);

    // Back-to-back 8'h00 then 8'hFF with valid_in held high.
    at(1);
    valid_in = 1'b1;
    data_i   = 8'h00;
    @(posedge clk);
    at(1);
    rel    = 1;
    data_i = 8'hFF;
    goto(FRAME);
    chk("b2b_stop", tx_o, 1'b1);
    chk("b2b_ready_lo", ready_in, 1'b0);
    goto(FRAME + 1);
    chk("b2b_gap_tx", tx_o, 1'b1);
    chk("b2b_gap_ready", ready_in, 1'b1);
    goto(FRAME + 2);
    valid_in = 1'b0;
    chk("b2b_fall", tx_o, 1'b0);
    chk("b2b_busy", busy_o, 1'b1);
    at(FRAME + 2);

    // Backpressure: 8'h3C offered mid-frame, accepted only when idle.
    launch(8'hA5);
    goto(10);
    valid_in = 1'b1;
    data_i   = 8'h3C;
    #1;
    chk("bp_ready_lo", ready_in, 1'b0);
    goto(FRAME);
    chk("bp_still_lo", ready_in, 1'b0);
    goto(FRAME + 1);
    chk("bp_ready_hi", ready_in, 1'b1);
    goto(FRAME + 2);
    valid_in = 1'b0;
    data_i   = 8'h55;
    chk("bp_fall", tx_o, 1'b0);
    goto(FRAME + 2 + 2 * CD + 1);
    chk("bp_3c_bit1", tx_o, 1'b0);
    goto(FRAME + 2 + 3 * CD + 1);
    chk("bp_3c_bit2", tx_o, 1'b1);
    at(FRAME + 2);

    // Reset during DATA, then a clean 8'h81.
    launch(8'h5A);
    goto(15);
    rst = 1'b1;
    goto(16);
    chk("mid_tx", tx_o, 1'b1);
    chk("mid_busy", busy_o, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_ready", ready_in, 1'b1);
    at(2);
    launch(8'h81);
    goto(6);
    chk("x81_bit0", tx_o, 1'b1);
    goto(10);
    chk("x81_bit1", tx_o, 1'b0);
    goto(34);
    chk("x81_bit7", tx_o, 1'b1);
    goto(FRAME + 1);
    chk("x81_ready", ready_in, 1'b1);

`ifdef UART_TX_PARITY_EN
    // Parity of 8'h07 is 1.
    at(2);
    launch(8'h07);
    goto(36);
    chk("p07_bit7", tx_o, 1'b0);
    goto(37);
    chk("p07_par_first", tx_o, 1'b1);
    goto(40);
    chk("p07_par_last", tx_o, 1'b1);
    goto(44);
    chk("p07_stop", tx_o, 1'b1);
    chk("p07_ready_lo", ready_in, 1'b0);
    goto(45);
    chk("p07_ready_hi", ready_in, 1'b1);
`endif

    at(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
